// File: rtl/wf_iq_capture.sv
// Multi-channel I/Q waveform capture buffer with power-of-two averaging,
// one-shot or continuous (wrapping) capture, and a strobed channel read port.
module wf_iq_capture #(
  parameter int CH           = 2,
  parameter int IN_WIDTH     = 16,
  parameter int DEPTH        = 1024,
  parameter int MAX_AVG_LOG2 = 4,
  localparam int AVG_W  = $clog2(MAX_AVG_LOG2 + 1),
  localparam int CHAN_W = (CH > 1) ? $clog2(CH) : 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   adc_clk,
  input  logic                   rst_n,
  input  logic                   cfg_load,
  input  logic                   cfg_continuous,
  input  logic [AVG_W-1:0]       cfg_avg_log2,
  input  logic                   wr_rst,
  input  logic                   in_strobe,
  input  logic [CH*IN_WIDTH-1:0] in_i,
  input  logic [CH*IN_WIDTH-1:0] in_q,
  input  logic                   rd_rst,
  input  logic                   rd_sync,
  input  logic [CHAN_W-1:0]      rd_chan,
  input  logic                   rd_i,
  input  logic                   rd_q,
  output logic [IN_WIDTH-1:0]    rd_data,
  output logic                   full,
  output logic [ADDR_W-1:0]      wr_addr
);

  localparam int ACC_W  = IN_WIDTH + MAX_AVG_LOG2;
  localparam int CNT_W  = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
  localparam int WORD_W = 2 * CH * IN_WIDTH;

  // RAM word layout: all I samples in the low half, all Q samples in the high half.
  logic [WORD_W-1:0] mem [DEPTH];

  logic              run_q;
  logic              shadow_cont;
  logic [AVG_W-1:0]  shadow_avg;
  logic              act_cont;
  logic [AVG_W-1:0]  act_avg;
  logic [AVG_W-1:0]  cfg_avg_clamped;

  logic signed [ACC_W-1:0] acc_i [CH];
  logic signed [ACC_W-1:0] acc_q [CH];
  logic signed [ACC_W-1:0] sum_i [CH];
  logic signed [ACC_W-1:0] sum_q [CH];
  logic signed [ACC_W-1:0] avg_i [CH];
  logic signed [ACC_W-1:0] avg_q [CH];
  logic [CNT_W-1:0]        cnt;
  logic [WORD_W-1:0]       wr_word;
  logic                    capture_en;
  logic                    last;
  logic                    do_write;

  logic [ADDR_W-1:0]   rd_addr;
  logic [WORD_W-1:0]   rd_word;
  logic [IN_WIDTH-1:0] rd_sel;

  // Reset release is retimed so the first capture lands on the second edge.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign cfg_avg_clamped = (cfg_avg_log2 > AVG_W'(MAX_AVG_LOG2)) ?
                           AVG_W'(MAX_AVG_LOG2) : cfg_avg_log2;

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_cont <= 1'b0;
      shadow_avg  <= '0;
    end else if (cfg_load) begin
      shadow_cont <= cfg_continuous;
      shadow_avg  <= cfg_avg_clamped;
    end
  end

  // A one-shot capture that has filled the buffer freezes until wr_rst.
  assign capture_en = run_q && in_strobe && !wr_rst && !(full && !act_cont);
  assign last       = (cnt == CNT_W'((32'd1 << act_avg) - 32'd1));
  assign do_write   = capture_en && last;

  always_comb begin
    wr_word = '0;
    for (int c = 0; c < CH; c++) begin
      sum_i[c] = acc_i[c] + {{MAX_AVG_LOG2{in_i[c*IN_WIDTH+IN_WIDTH-1]}},
                             in_i[c*IN_WIDTH +: IN_WIDTH]};
      sum_q[c] = acc_q[c] + {{MAX_AVG_LOG2{in_q[c*IN_WIDTH+IN_WIDTH-1]}},
                             in_q[c*IN_WIDTH +: IN_WIDTH]};
      avg_i[c] = sum_i[c] >>> act_avg;
      avg_q[c] = sum_q[c] >>> act_avg;
      wr_word[c*IN_WIDTH +: IN_WIDTH]        = avg_i[c][IN_WIDTH-1:0];
      wr_word[(CH+c)*IN_WIDTH +: IN_WIDTH]   = avg_q[c][IN_WIDTH-1:0];
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        acc_i[c] <= '0;
        acc_q[c] <= '0;
      end
      cnt      <= '0;
      wr_addr  <= '0;
      full     <= 1'b0;
      act_cont <= 1'b0;
      act_avg  <= '0;
    end else if (wr_rst) begin
      for (int c = 0; c < CH; c++) begin
        acc_i[c] <= '0;
        acc_q[c] <= '0;
      end
      cnt      <= '0;
      wr_addr  <= '0;
      full     <= 1'b0;
      act_cont <= shadow_cont;
      act_avg  <= shadow_avg;
    end else if (capture_en) begin
      if (last) begin
        for (int c = 0; c < CH; c++) begin
          acc_i[c] <= '0;
          acc_q[c] <= '0;
        end
        cnt     <= '0;
        wr_addr <= wr_addr + ADDR_W'(1);
        if (wr_addr == ADDR_W'(DEPTH - 1)) full <= 1'b1;
      end else begin
        for (int c = 0; c < CH; c++) begin
          acc_i[c] <= sum_i[c];
          acc_q[c] <= sum_q[c];
        end
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    if (do_write) mem[wr_addr] <= wr_word;
  end

  // Read side: same-cycle write to rd_addr returns the previous word.
  assign rd_word = mem[rd_addr];

  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < CH; c++) begin
      if (rd_chan == CHAN_W'(c)) begin
        rd_sel = rd_q ? rd_word[(CH+c)*IN_WIDTH +: IN_WIDTH]
                      : rd_word[c*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      if (rd_rst)      rd_addr <= '0;
      else if (rd_sync) rd_addr <= wr_addr;
      else if (rd_q)    rd_addr <= rd_addr + ADDR_W'(1);
      if (rd_i || rd_q) rd_data <= rd_sel;
    end
  end

endmodule

// File: doc/wf_iq_capture.md
WF_IQ_CAPTURE -- requirements
Module: wf_iq_capture

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  - CH, 2, number of I/Q channels (1..8).
  - IN_WIDTH, 16, signed sample width.
  - DEPTH, 1024, words per channel (power of two).
  - MAX_AVG_LOG2, 4, maximum log2 averaging factor.
REQ-002 The module SHALL have one clock, adc_clk, and an asynchronous, active-low reset, rst_n.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
  - adc_clk, in, 1, sole clock.
  - rst_n, in, 1, async active-low reset.
  - cfg_load, in, 1, latch cfg_continuous and cfg_avg_log2 into shadow registers.
  - cfg_continuous, in, 1, 1 = wrap mode, 0 = one-shot.
  - cfg_avg_log2, in, clog2(MAX_AVG_LOG2+1), log2 of averaging factor.
  - wr_rst, in, 1, restart capture.
  - in_strobe, in, 1, input sample valid.
  - in_i, in, CH*IN_WIDTH, packed I (ch0 in LSBs).
  - in_q, in, CH*IN_WIDTH, packed Q.
  - rd_rst, in, 1, read address := 0.
  - rd_sync, in, 1, read address := write address.
  - rd_chan, in, max(1,clog2(CH)), channel to read.
  - rd_i, in, 1, read I strobe.
  - rd_q, in, 1, read Q strobe, advances address.
  - rd_data, out, IN_WIDTH, read result.
  - full, out, 1, buffer filled at least once.
  - wr_addr, out, clog2(DEPTH), current write address.

Function
REQ-004 cfg_load SHALL update shadow config only; shadow SHALL be applied to the active config on wr_rst, never mid-capture.
REQ-005 Per channel, the block SHALL accumulate 2^avg in_strobe samples of I and Q in signed accumulators IN_WIDTH+MAX_AVG_LOG2 wide, with no overflow possible.
REQ-006 On the 2^avg-th strobe, the block SHALL write the result for all channels to RAM at wr_addr in one word (CH*2*IN_WIDTH bits), clear the accumulators and increment wr_addr.
  - Result = (sum of 2^avg samples including the current one) arithmetically right-shifted by avg, truncating.
  - Write latency <= 2 cycles after the final strobe.
REQ-007 avg=0 SHALL write every strobed sample unchanged.
REQ-008 cfg_avg_log2 > MAX_AVG_LOG2 SHALL be clamped to MAX_AVG_LOG2.
REQ-009 wr_addr SHALL wrap DEPTH-1 -> 0.
  - On the first wrap, full SHALL go to 1 and stay 1 until wr_rst or reset.
REQ-010 One-shot mode, once full=1:
  - No further RAM writes.
  - in_strobe ignored, accumulators frozen.
  - wr_addr holds at 0.
REQ-011 Continuous mode SHALL keep writing after wrap, overwriting the oldest words.
REQ-012 wr_rst SHALL, in the same clock edge:
  - clear accumulators, sample counter, wr_addr and full;
  - apply the shadow config.
  If wr_rst and in_strobe coincide, wr_rst wins and the sample is discarded.
REQ-013 rd_i SHALL load rd_data with the I of rd_chan at rd_addr on the next edge; rd_addr is unchanged.
REQ-014 rd_q SHALL load rd_data with the Q of rd_chan at rd_addr and increment rd_addr, wrapping at DEPTH.
  - If rd_i and rd_q coincide, rd_q behaviour applies.
REQ-015 rd_data SHALL hold its value between strobes.
  - RAM read latency is hidden: rd_data is valid one cycle after the strobe.
  - Back-to-back strobes on every cycle SHALL be supported.
REQ-016 Read-address priority SHALL be: rd_rst over rd_sync over rd_q increment.
  - rd_sync loads the wr_addr value from before any same-cycle write increment.
REQ-017 Reads and writes to the same address in the same cycle SHALL return the old data.
  - No read/write overlap checking is performed.
REQ-018 rd_chan >= CH SHALL return 0.

Reset
REQ-019 rst_n low SHALL asynchronously clear:
  - accumulators, sample counter, wr_addr, rd_addr, full, rd_data;
  - active and shadow config (one-shot, avg=0).
  RAM contents are not reset.
REQ-020 Reset release SHALL be synchronised internally.
  - The first capture is allowed on the second adc_clk edge after rst_n rises.
REQ-021 Reset asserted mid-accumulation SHALL discard the partial sum; no RAM write occurs.

Verification
REQ-022 One-shot, avg=0, DEPTH=8:
  - Stimulus: ch0 I = 1..10.
  - Required: full=1 after the 8th strobe; RAM holds 1..8; rd sequence returns 1..8.
REQ-023 avg=2:
  - Stimulus: I samples 3, 4, 5, -7.
  - Required: stored value is 1 (sum 5 >>> 2); accumulator cleared afterwards.
REQ-024 Continuous, DEPTH=8:
  - Stimulus: 11 samples 1..11, then rd_sync.
  - Required: reads return 4..11; full=1; wr_addr=3.
REQ-025 cfg_load avg=3 mid-capture with avg=0 active:
  - Required: writes continue per sample until wr_rst; after wr_rst, one write per 8 strobes.
REQ-026 wr_rst coincident with in_strobe:
  - Required: sample dropped; wr_addr=0, full=0.
  - Also: rd_i then rd_q on consecutive cycles for CH=2, rd_chan=1 returns that channel's I then Q, and rd_addr increments once.
